// File: rtl/simple_processor_instr_sequencer.sv
// Instruction sequencer for simple_processor_Top: holds a small program RAM, issues one
// instruction (plus mvi immediate) per Run pulse, waits for Done and captures Bus.
module simple_processor_instr_sequencer #(
  parameter int DW      = 9,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          Done,
  input  logic [DW-1:0] Bus,
  output logic [DW-1:0] DIN,
  output logic          Run,
  output logic          busy,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          prog_done,
  output logic [1:0]    err,
  output logic [1:0]    state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MVI = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t        state;
  logic [AW:0]   pc;
  logic [AW:0]   len;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] mem [DEPTH];

  logic [AW:0]   ipc, ilen, ipc_n1, pc_n1;
  logic [DW-1:0] iinst, imm;
  logic          ibad;

  assign state_dbg = state;

  always_ff @(posedge Clock) begin
    if (prog_we && !busy && (32'(prog_addr) < DEPTH))
      mem[prog_addr] <= prog_data;
  end

  // Decode of the next instruction to issue, so Run and DIN can be registered on the
  // same edge that enters ISSUE; an mvi without room for its immediate aborts instead.
  always_comb begin
    ipc    = (state == S_IDLE) ? '0 : pc;
    ilen   = (state == S_IDLE) ? prog_len : len;
    ipc_n1 = ipc + (AW+1)'(1);
    iinst  = mem[ipc[AW-1:0]];
    ibad   = (iinst[DW-1 -: 3] == OP_MVI) && (ipc_n1 >= ilen);
    pc_n1  = pc + (AW+1)'(1);
    imm    = mem[pc_n1[AW-1:0]];
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      pc           <= '0;
      len          <= '0;
      tcnt         <= '0;
      DIN          <= '0;
      Run          <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      prog_done    <= 1'b0;
      err          <= 2'b00;
    end else begin
      Run          <= 1'b0;
      result_valid <= 1'b0;
      prog_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err <= 2'b00;
            if (prog_len != '0) begin
              len <= prog_len;
              pc  <= '0;
              if (ibad) begin
                err <= 2'b10;
              end else begin
                state <= S_ISSUE;
                Run   <= 1'b1;
                DIN   <= iinst;
                busy  <= 1'b1;
              end
            end else begin
              prog_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          tcnt  <= '0;
          if (DIN[DW-1 -: 3] == OP_MVI) begin
            DIN <= imm;
            pc  <= pc + (AW+1)'(2);
          end else begin
            pc  <= pc_n1;
          end
        end
        S_WAIT: begin
          if (Done) begin
            result       <= Bus;
            result_valid <= 1'b1;
            if (pc < len) begin
              if (ibad) begin
                err[1] <= 1'b1;
                state  <= S_IDLE;
                busy   <= 1'b0;
                DIN    <= '0;
              end else begin
                state <= S_ISSUE;
                Run   <= 1'b1;
                DIN   <= iinst;
              end
            end else begin
              state     <= S_FINISH;
              prog_done <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err[0] <= 1'b1;
            state  <= S_IDLE;
            busy   <= 1'b0;
            DIN    <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_processor_instr_sequencer.sv
// Directed bench for simple_processor_instr_sequencer with a small behavioural
// processor (mvi/add/mv) answering Run with Done after a programmable delay.
module tb_simple_processor_instr_sequencer;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [8:0] prog_data = '0;
  logic [4:0] prog_len = '0;
  logic       start = 1'b0;
  logic       Done;
  logic [8:0] Bus;
  logic [8:0] DIN;
  logic       Run, busy, result_valid, prog_done;
  logic [8:0] result;
  logic [1:0] err, state_dbg;

  simple_processor_instr_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .Done(Done), .Bus(Bus),
    .DIN(DIN), .Run(Run), .busy(busy), .result(result), .result_valid(result_valid),
    .prog_done(prog_done), .err(err), .state_dbg(state_dbg)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  logic [8:0] din_q[$];
  int run_cnt, rv_cnt, pd_cnt, run2_cyc, done_cyc;
  logic last_run = 1'b0;
  int done_dly = 3;
  logic proc_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural processor: latches DIN on Run, immediate one cycle later for mvi.
  logic [8:0] rf [8];
  logic [8:0] ir, val;
  initial begin
    Done = 1'b0;
    Bus  = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    forever begin
      @(negedge Clock);
      while (Run && Resetn) begin
        ir = DIN;
        @(negedge Clock);
        case (ir[8:6])
          3'b011:  rf[ir[5:3]] = DIN;
          3'b001:  rf[ir[5:3]] = rf[ir[5:3]] + rf[ir[2:0]];
          default: rf[ir[5:3]] = rf[ir[2:0]];
        endcase
        val = rf[ir[5:3]];
        if (proc_en) begin
          repeat (done_dly - 1) @(negedge Clock);
          Done = 1'b1;
          Bus  = val;
          if (done_cyc < 0) done_cyc = cyc;
          @(negedge Clock);
          Done = 1'b0;
        end
      end
    end
  end

  // Monitor and scoreboard, sampled just after the rising edge.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (last_run) din_q.push_back(DIN);
      last_run = Run;
      if (Run) begin
        run_cnt++;
        din_q.push_back(DIN);
        if (run_cnt == 2) run2_cyc = cyc;
      end
      if (prog_done) pd_cnt++;
      if (result_valid) begin
        rv_cnt++;
        if (exp_q.size() == 0) check("result_unexp", 32'(exp_q.size()), 1);
        else check("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic clear_mon();
    run_cnt = 0; rv_cnt = 0; pd_cnt = 0; run2_cyc = -1; done_cyc = -1;
    din_q.delete();
  endtask

  task automatic load(input logic [3:0] a, input logic [8:0] d);
    @(negedge Clock);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge Clock);
    prog_we = 1'b0;
  endtask

  task automatic start_prog(input logic [4:0] l);
    @(negedge Clock);
    prog_len = l; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic load_t2();
    load(4'd0, 9'h0C0); load(4'd1, 9'h1CF); load(4'd2, 9'h0D0);
    load(4'd3, 9'h1F0); load(4'd4, 9'h042);
  endtask

  task automatic push_t2();
    exp_q.push_back(9'h1CF); exp_q.push_back(9'h1F0); exp_q.push_back(9'h1BF);
  endtask

  initial begin
    clear_mon();
    repeat (2) @(negedge Clock);
    check("rst_din", DIN, 0);
    check("rst_run", Run, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    check("rst_pd", prog_done, 0);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, 0);
    Resetn = 1'b1;

    // T1: mvi R0 with immediate
    load(4'd0, 9'h0C1); load(4'd1, 9'h10F);
    clear_mon(); exp_q.push_back(9'h10F);
    start_prog(5'd2);
    repeat (20) @(negedge Clock);
    check("t1_runs", run_cnt, 1);
    check("t1_din_instr", din_q.size() > 0 ? din_q[0] : 9'h000, 9'h0C1);
    check("t1_din_imm", din_q.size() > 1 ? din_q[1] : 9'h000, 9'h10F);
    check("t1_rv", rv_cnt, 1);
    check("t1_pd", pd_cnt, 1);
    check("t1_err", err, 0);
    check("t1_busy", busy, 0);
    check("t1_expq", exp_q.size(), 0);

    // T2: mvi, mvi, add
    load_t2();
    clear_mon(); push_t2();
    start_prog(5'd5);
    repeat (30) @(negedge Clock);
    check("t2_runs", run_cnt, 3);
    check("t2_done_to_run", run2_cyc - done_cyc, 1);
    check("t2_pd", pd_cnt, 1);
    check("t2_err", err, 0);
    check("t2_expq", exp_q.size(), 0);

    // T3: mvi as last word has no immediate
    load(4'd0, 9'h0C1);
    clear_mon();
    start_prog(5'd1);
    repeat (10) @(negedge Clock);
    check("t3_runs", run_cnt, 0);
    check("t3_err", err, 2'b10);
    check("t3_busy", busy, 0);
    check("t3_pd", pd_cnt, 0);

    // T4: Done never arrives
    load(4'd0, 9'h042);
    proc_en = 1'b0;
    clear_mon();
    start_prog(5'd1);
    repeat (8) @(negedge Clock);
    check("t4_busy_before_to", busy, 1);
    check("t4_err_before_to", err, 0);
    @(negedge Clock);
    check("t4_err", err, 2'b01);
    check("t4_busy", busy, 0);
    repeat (10) @(negedge Clock);
    check("t4_runs", run_cnt, 1);
    check("t4_run_low", Run, 0);
    check("t4_rv", rv_cnt, 0);
    proc_en = 1'b1;

    // T5: asynchronous reset while waiting for Done, then rerun
    load_t2();
    done_dly = 6;
    clear_mon();
    start_prog(5'd5);
    repeat (3) @(negedge Clock);
    check("t5_busy_pre", busy, 1);
    #2 Resetn = 1'b0;
    #1;
    check("t5_rst_run", Run, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_din", DIN, 0);
    check("t5_rst_result", result, 0);
    check("t5_rst_err", err, 0);
    check("t5_rst_state", state_dbg, 0);
    repeat (10) @(negedge Clock);
    Resetn = 1'b1;
    done_dly = 3;
    clear_mon(); push_t2();
    start_prog(5'd5);
    repeat (30) @(negedge Clock);
    check("t5_runs", run_cnt, 3);
    check("t5_pd", pd_cnt, 1);
    check("t5_expq", exp_q.size(), 0);

    // T6: start/prog_we while busy are ignored; zero-length start only pulses prog_done
    clear_mon(); push_t2();
    start_prog(5'd5);
    @(negedge Clock);
    prog_we = 1'b1; prog_addr = 4'd4; prog_data = 9'h000;
    start = 1'b1; prog_len = 5'd1;
    @(negedge Clock);
    prog_we = 1'b0; start = 1'b0;
    repeat (30) @(negedge Clock);
    check("t6_runs", run_cnt, 3);
    check("t6_pd", pd_cnt, 1);
    check("t6_expq", exp_q.size(), 0);
    clear_mon();
    start_prog(5'd0);
    repeat (5) @(negedge Clock);
    check("t6_len0_pd", pd_cnt, 1);
    check("t6_len0_runs", run_cnt, 0);
    check("t6_len0_busy", busy, 0);
    check("t6_len0_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
